// File: rtl/scan_decoder_pkg.sv
// scan_decoder_pkg: shared mode codes and one-hot helper
// for the N-to-2^N scan decoder family.
package scan_decoder_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Widest decode (ADDR_W = 6); callers cast down to OUT_W.
   function automatic logic [63:0] onehot(
      input logic [5:0] addr,
      input logic       active_low
   );
      logic [63:0] v;
      v = 64'd1 << addr;
      return active_low ? ~v : v;
   endfunction

endpackage

// File: rtl/scan_decoder_nto2n_prescaler.sv
// scan_prescaler: free-running 0..SCAN_DIV-1 divider with
// synchronous clear; tick marks the last count of a step.
module scan_prescaler #(
   parameter int SCAN_DIV = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic clear_i,
   input  logic run_i,
   output logic tick_o
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] TOP = PW'(SCAN_DIV - 1);

   logic [PW-1:0] pre_q, pre_d;
   logic          at_top;

   // Next count; clear wins and also suppresses the tick.
   always_comb begin
      at_top = (pre_q == TOP);
      tick_o = run_i & ~clear_i & at_top;
      pre_d  = pre_q;
      if (clear_i)
         pre_d = '0;
      else if (run_i)
         pre_d = at_top ? '0 : pre_q + PW'(1);
   end

   // Prescaler register.
   always_ff @(posedge clock) begin
      if (reset)
         pre_q <= '0;
      else
         pre_q <= pre_d;
   end

endmodule

// File: rtl/scan_decoder_nto2n.sv
// scan_decoder_nto2n: registered 74LS138-style decoder with
// triple enable and a prescaled scan counter mode.
module scan_decoder_nto2n
   import scan_decoder_pkg::*;
#(
   parameter int ADDR_W     = 3,
   parameter int SCAN_DIV   = 4,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   g1,
   input  logic                   g2a_n,
   input  logic                   g2b_n,
   input  logic                   mode,
   input  logic [ADDR_W-1:0]      addr_in,
   input  logic                   load,
   input  logic [ADDR_W-1:0]      scan_last,
   output logic [2**ADDR_W-1:0]   y,
   output logic [ADDR_W-1:0]      sel_out,
   output logic                   valid,
   output logic                   wrap
);

   localparam int OUT_W = 2**ADDR_W;
   localparam logic INACT = (ACTIVE_LOW != 0);
   localparam logic [OUT_W-1:0] Y_OFF = {OUT_W{INACT}};

   logic              en, scan, mode_chg, do_load, clr, tick;
   logic              mode_q;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] sel_q, sel_d;
   logic [OUT_W-1:0]  y_q, y_d;
   logic              valid_q, valid_d;
   logic              wrap_q, wrap_d;

   scan_prescaler #(
      .SCAN_DIV (SCAN_DIV)
   ) u_pre (
      .clock   (clock),
      .reset   (reset),
      .clear_i (clr),
      .run_i   (scan & en),
      .tick_o  (tick)
   );

   // Enable, mode and load qualification; tick is already
   // gated by clr, so load and mode change beat a step.
   always_comb begin
      en       = g1 & ~g2a_n & ~g2b_n;
      scan     = (mode == MODE_SCAN);
      mode_chg = (mode != mode_q);
      do_load  = scan & load;
      clr      = mode_chg | do_load;
   end

   // Counter step and next output image.
   always_comb begin
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      y_d     = Y_OFF;
      valid_d = 1'b0;
      wrap_d  = 1'b0;
      if (!scan) begin
         sel_d = addr_in;
         if (en) begin
            y_d     = OUT_W'(onehot(6'(addr_in), INACT));
            valid_d = 1'b1;
         end
      end else begin
         if (do_load) begin
            cnt_d = addr_in;
         end else if (tick) begin
            if (cnt_q >= scan_last) begin
               cnt_d  = '0;
               wrap_d = 1'b1;
            end else begin
               cnt_d = cnt_q + ADDR_W'(1);
            end
         end
         sel_d = cnt_d;
         if (en) begin
            y_d     = OUT_W'(onehot(6'(cnt_d), INACT));
            valid_d = 1'b1;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         mode_q  <= MODE_DIRECT;
         cnt_q   <= '0;
         sel_q   <= '0;
         y_q     <= Y_OFF;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         mode_q  <= mode;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         y_q     <= y_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
      end
   end

   assign y       = y_q;
   assign sel_out = sel_q;
   assign valid   = valid_q;
   assign wrap    = wrap_q;

endmodule

// File: tb/tb_scan_decoder_nto2n.sv
// tb_scan_decoder_nto2n: directed vectors for the scan
// decoder, default build plus a DIV=1 active-high build.
module tb_scan_decoder_nto2n;

   logic       clock = 1'b0;
   logic       reset, g1, g2a_n, g2b_n, mode, load;
   logic [2:0] addr_in, scan_last;
   logic [7:0] y1, y2;
   logic [2:0] sel1, sel2;
   logic       valid1, valid2, wrap1, wrap2;

   int n_chk = 0;
   int n_fail = 0;

   logic [7:0] lo_tbl [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7,
                              8'hEF, 8'hDF, 8'hBF, 8'h7F};

   always #5 clock = ~clock;

   scan_decoder_nto2n #(
      .ADDR_W(3), .SCAN_DIV(4), .ACTIVE_LOW(1)
   ) dut (
      .clock(clock), .reset(reset), .g1(g1),
      .g2a_n(g2a_n), .g2b_n(g2b_n), .mode(mode),
      .addr_in(addr_in), .load(load),
      .scan_last(scan_last), .y(y1), .sel_out(sel1),
      .valid(valid1), .wrap(wrap1)
   );

   scan_decoder_nto2n #(
      .ADDR_W(3), .SCAN_DIV(1), .ACTIVE_LOW(0)
   ) dut2 (
      .clock(clock), .reset(reset), .g1(g1),
      .g2a_n(g2a_n), .g2b_n(g2b_n), .mode(mode),
      .addr_in(addr_in), .load(load),
      .scan_last(scan_last), .y(y2), .sel_out(sel2),
      .valid(valid2), .wrap(wrap2)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk1(input string tag, input int idx,
                       input logic v, input logic w);
      chk({tag, ".sel"}, 32'(sel1), 32'(idx));
      chk({tag, ".y"}, 32'(y1), v ? 32'(lo_tbl[idx]) : 32'hFF);
      chk({tag, ".valid"}, 32'(valid1), 32'(v));
      chk({tag, ".wrap"}, 32'(wrap1), 32'(w));
   endtask

   initial begin
      reset = 1'b1; g1 = 1'b0; g2a_n = 1'b1; g2b_n = 1'b1;
      mode = 1'b0; load = 1'b0; addr_in = 3'd0;
      scan_last = 3'd7;
      #1;
      step(); step();
      chk("rst.y", 32'(y1), 32'hFF);
      chk("rst.sel", 32'(sel1), 32'd0);
      chk("rst.valid", 32'(valid1), 32'd0);
      chk("rst.wrap", 32'(wrap1), 32'd0);
      chk("rst.y2", 32'(y2), 32'h00);

      // 1: direct decode, then mid-run reset
      reset = 1'b0; g1 = 1'b1; g2a_n = 1'b0; g2b_n = 1'b0;
      addr_in = 3'd5;
      step();
      chk("d5.y", 32'(y1), 32'hDF);
      chk("d5.sel", 32'(sel1), 32'd5);
      chk("d5.valid", 32'(valid1), 32'd1);
      reset = 1'b1;
      step();
      chk("midrst.y", 32'(y1), 32'hFF);
      chk("midrst.valid", 32'(valid1), 32'd0);
      reset = 1'b0;

      // 2: enable truth table, then address sweep
      g1 = 1'b0; step();
      chk("g1lo.y", 32'(y1), 32'hFF);
      chk("g1lo.valid", 32'(valid1), 32'd0);
      g1 = 1'b1; g2a_n = 1'b1; step();
      chk("g2a.y", 32'(y1), 32'hFF);
      chk("g2a.valid", 32'(valid1), 32'd0);
      g2a_n = 1'b0; g2b_n = 1'b1; step();
      chk("g2b.y", 32'(y1), 32'hFF);
      chk("g2b.valid", 32'(valid1), 32'd0);
      g2b_n = 1'b0;
      for (int a = 0; a < 8; a++) begin
         addr_in = 3'(a);
         step();
         chk1("sweep", a, 1'b1, 1'b0);
      end

      // 3: scan 0..7 from reset, 4 cycles per step
      reset = 1'b1; step();
      reset = 1'b0; mode = 1'b1; scan_last = 3'd7;
      step();
      chk1("s3.first", 0, 1'b1, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         repeat (3) begin
            step();
            chk1("s3.hold", (k - 1) % 8, 1'b1, 1'b0);
         end
         step();
         chk1("s3.step", k % 8, 1'b1, k == 8);
      end

      // 4: load beyond scan_last, then load vs tick
      scan_last = 3'd2; load = 1'b1; addr_in = 3'd6;
      step();
      load = 1'b0;
      chk1("s4.load", 6, 1'b1, 1'b0);
      repeat (3) begin
         step();
         chk1("s4.hold6", 6, 1'b1, 1'b0);
      end
      step();
      chk1("s4.wrap", 0, 1'b1, 1'b1);
      for (int k = 1; k <= 3; k++) begin
         repeat (3) step();
         step();
         chk1("s4.seq", k % 3, 1'b1, k == 3);
      end
      repeat (3) step();
      load = 1'b1; addr_in = 3'd5;
      step();
      load = 1'b0;
      chk1("s4.ldwin", 5, 1'b1, 1'b0);
      repeat (3) step();
      step();
      chk1("s4.ldwrap", 0, 1'b1, 1'b1);

      // 5: freeze while disabled, full dwell afterwards
      scan_last = 3'd7; load = 1'b1; addr_in = 3'd3;
      step();
      load = 1'b0;
      chk1("s5.at3", 3, 1'b1, 1'b0);
      g1 = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         chk1("s5.off", 3, 1'b0, 1'b0);
      end
      g1 = 1'b1;
      repeat (3) begin
         step();
         chk1("s5.dwell", 3, 1'b1, 1'b0);
      end
      step();
      chk1("s5.step", 4, 1'b1, 1'b0);

      // 6: DIV=1 active-high build, scan_last = 0
      reset = 1'b1; mode = 1'b1; scan_last = 3'd0;
      addr_in = 3'd0; load = 1'b0;
      step();
      reset = 1'b0;
      step();
      chk("s6.first.y", 32'(y2), 32'h01);
      chk("s6.first.wrap", 32'(wrap2), 32'd0);
      repeat (4) begin
         step();
         chk("s6.y", 32'(y2), 32'h01);
         chk("s6.wrap", 32'(wrap2), 32'd1);
         chk("s6.valid", 32'(valid2), 32'd1);
      end
      mode = 1'b0;
      repeat (2) begin
         step();
         chk("s6.dir.y", 32'(y2), 32'h01);
         chk("s6.dir.wrap", 32'(wrap2), 32'd0);
      end
      mode = 1'b1;
      step();
      chk("s6.back.y", 32'(y2), 32'h01);
      chk("s6.back.wrap", 32'(wrap2), 32'd0);
      step();
      chk("s6.run.y", 32'(y2), 32'h01);
      chk("s6.run.wrap", 32'(wrap2), 32'd1);
      chk("s6.run.sel", 32'(sel2), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
